fwrisc_trace_buf: RTL

Parametrised trace-capture buffer for the fwrisc core: observes instruction-retire, register-write and memory-write events, filters them through a programmable configuration (PC breakpoints, memory-watch regions, jump/call filters), and queues packed trace records in a FIFO drained over a valid/ready stream. It sits beside the core in the verification environment. It replaces per-event task calls with a synthesizable buffered record stream, so trace can run in emulation.

---
 rtl/fwrisc_trace_buf_if.sv | 16 +
 rtl/fwrisc_trace_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwrisc_trace_buf_if.sv
// Trace-record stream out of fwrisc_trace_buf: valid/ready handshake plus packed record.
// Record width follows FWRISC_TRACE_TIMESTAMP_EN (106 bits with timestamp, 74 without).
interface fwrisc_trace_buf_if #(
`ifdef FWRISC_TRACE_TIMESTAMP_EN
    parameter int unsigned REC_W = 106
`else
    parameter int unsigned REC_W = 74
`endif
);
    logic             out_valid;
    logic             out_ready;
    logic [REC_W-1:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/fwrisc_trace_buf.sv
// Trace-capture buffer for fwrisc: filters retire/reg/mem events into packed records queued
// in a FIFO. Define FWRISC_TRACE_TIMESTAMP_EN to prepend a 32-bit cycle stamp to each record.
module fwrisc_trace_buf #(
    parameter int unsigned N_HW_BP      = 8,
    parameter int unsigned N_MW_REGIONS = 4,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           pc,
    input  logic [31:0]           instr,
    input  logic                  ivalid,
    input  logic [5:0]            rd_waddr,
    input  logic [31:0]           rd_wdata,
    input  logic                  rd_write,
    input  logic [31:0]           maddr,
    input  logic [31:0]           mdata,
    input  logic [3:0]            mstrb,
    input  logic                  mwrite,
    input  logic                  mvalid,
    input  logic                  cfg_we,
    input  logic [7:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    fwrisc_trace_buf_if.master    trace
);
`ifdef FWRISC_TRACE_TIMESTAMP_EN
    localparam int unsigned REC_W = 106;
`else
    localparam int unsigned REC_W = 74;
`endif
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [5:0]              ctrl_q;
    logic [N_MW_REGIONS-1:0] mw_valid_q;
    logic [31:0]             bp_q       [N_HW_BP];
    logic [31:0]             mw_base_q  [N_MW_REGIONS];
    logic [31:0]             mw_limit_q [N_MW_REGIONS];
    logic [9:0]              drop_q     [3];
    logic [11:0]             prev_instr_q;
    logic                    drop_clr;

    assign drop_clr = cfg_we && (cfg_addr == 8'h02);

    always_ff @(posedge clock) begin
        if (!reset) begin
            ctrl_q     <= 6'h3F;
            mw_valid_q <= '0;
            for (int i = 0; i < N_HW_BP; i++) bp_q[i] <= '0;
            for (int i = 0; i < N_MW_REGIONS; i++) begin
                mw_base_q[i]  <= '0;
                mw_limit_q[i] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_addr == 8'h00) ctrl_q <= cfg_wdata[5:0];
            if (cfg_addr == 8'h01) mw_valid_q <= cfg_wdata[N_MW_REGIONS-1:0];
            for (int i = 0; i < N_HW_BP; i++) begin
                if (cfg_addr == 8'(8'h40 + i)) bp_q[i] <= cfg_wdata;
            end
            for (int i = 0; i < N_MW_REGIONS; i++) begin
                if (cfg_addr == 8'(8'h80 + 2 * i)) mw_base_q[i]  <= cfg_wdata;
                if (cfg_addr == 8'(8'h81 + 2 * i)) mw_limit_q[i] <= cfg_wdata;
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        if (cfg_addr == 8'h00) cfg_rdata = {26'b0, ctrl_q};
        if (cfg_addr == 8'h01) cfg_rdata[N_MW_REGIONS-1:0] = mw_valid_q;
        if (cfg_addr == 8'h02) cfg_rdata = {2'b0, drop_q[2], drop_q[1], drop_q[0]};
        for (int i = 0; i < N_HW_BP; i++) begin
            if (cfg_addr == 8'(8'h40 + i)) cfg_rdata = bp_q[i];
        end
        for (int i = 0; i < N_MW_REGIONS; i++) begin
            if (cfg_addr == 8'(8'h80 + 2 * i)) cfg_rdata = mw_base_q[i];
            if (cfg_addr == 8'(8'h81 + 2 * i)) cfg_rdata = mw_limit_q[i];
        end
    end

`ifdef FWRISC_TRACE_TIMESTAMP_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clock) begin
        if (!reset) cycle_q <= '0;
        else        cycle_q <= cycle_q + 32'd1;
    end
`endif

    // Event filtering
    logic       bp_hit, region_hit, prev_is_jump, prev_rd_nz;
    logic [2:0] ev;

    always_comb begin
        bp_hit     = 1'b0;
        region_hit = 1'b0;
        for (int i = 0; i < N_HW_BP; i++) begin
            if (bp_q[i][0] && (bp_q[i][31:1] == pc[31:1])) bp_hit = 1'b1;
        end
        for (int i = 0; i < N_MW_REGIONS; i++) begin
            if (mw_valid_q[i] && (maddr >= mw_base_q[i]) && (maddr <= mw_limit_q[i])) begin
                region_hit = 1'b1;
            end
        end
    end

    assign prev_is_jump = (prev_instr_q[6:0] == 7'h6F) || (prev_instr_q[6:0] == 7'h67);
    assign prev_rd_nz   = |prev_instr_q[11:7];

    assign ev[0] = ivalid && ctrl_q[5] &&
                   (ctrl_q[0] || bp_hit || (ctrl_q[1] && prev_is_jump) ||
                    (ctrl_q[2] && prev_is_jump && prev_rd_nz));
    assign ev[1] = rd_write && (rd_waddr != 6'd0) && ctrl_q[3] && ctrl_q[5];
    assign ev[2] = mvalid && mwrite && ctrl_q[5] && (ctrl_q[4] || region_hit);

    logic [73:0]      base_rec [3];
    logic [REC_W-1:0] rec      [3];

    assign base_rec[0] = {2'd0, pc, instr, 7'b0, bp_hit};
    assign base_rec[1] = {2'd1, 26'b0, rd_waddr, rd_wdata, 8'h00};
    assign base_rec[2] = {2'd2, maddr, mdata, 3'b0, region_hit, mstrb};

    always_comb begin
        for (int c = 0; c < 3; c++) begin
`ifdef FWRISC_TRACE_TIMESTAMP_EN
            rec[c] = {cycle_q, base_rec[c]};
`else
            rec[c] = base_rec[c];
`endif
        end
    end

    // Pending slots and fixed-priority arbiter (instr > reg > mem)
    logic [2:0]       pend_v_q, pend_v_d, drain, drop;
    logic [REC_W-1:0] pend_q [3];
    logic [REC_W-1:0] pend_d [3];
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic             pop, push, can_push;
    logic [REC_W-1:0] push_data;

    assign pop      = (count_q != '0) && trace.out_ready;
    assign can_push = (count_q < CW'(DEPTH)) || pop;

    always_comb begin
        drain     = '0;
        push_data = pend_q[0];
        if (can_push) begin
            if (pend_v_q[0]) begin
                drain[0]  = 1'b1;
                push_data = pend_q[0];
            end else if (pend_v_q[1]) begin
                drain[1]  = 1'b1;
                push_data = pend_q[1];
            end else if (pend_v_q[2]) begin
                drain[2]  = 1'b1;
                push_data = pend_q[2];
            end
        end
    end

    assign push = |drain;

    // A slot drained this cycle may be refilled in the same cycle without a drop.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            pend_v_d[c] = pend_v_q[c] && !drain[c];
            pend_d[c]   = pend_q[c];
            drop[c]     = 1'b0;
            if (ev[c]) begin
                if (pend_v_q[c] && !drain[c]) begin
                    drop[c] = 1'b1;
                end else begin
                    pend_v_d[c] = 1'b1;
                    pend_d[c]   = rec[c];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pend_v_q     <= '0;
            prev_instr_q <= '0;
            for (int c = 0; c < 3; c++) begin
                pend_q[c] <= '0;
                drop_q[c] <= '0;
            end
        end else begin
            pend_v_q <= pend_v_d;
            if (ivalid) prev_instr_q <= instr[11:0];
            for (int c = 0; c < 3; c++) begin
                pend_q[c] <= pend_d[c];
                if (drop_clr) begin
                    drop_q[c] <= '0;
                end else if (drop[c] && (drop_q[c] != 10'h3FF)) begin
                    drop_q[c] <= drop_q[c] + 10'd1;
                end
            end
        end
    end

    // Record FIFO
    logic [REC_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign trace.out_valid = (count_q != '0);
    assign trace.out_data  = mem_q[rd_ptr_q];

endmodule
